// File: rtl/logic_unit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_serial_pkg
// Description : Op codes and FSM state encoding shared by the serial logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_serial_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/logic_unit_serial_slice.sv
`default_nettype none
// ============================================================================
// Module      : logic_slice
// Description : Combinational SLICE-bit logic operation built from gate primitives.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_slice
    import logic_unit_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    wire [SLICE-1:0] w_and;
    wire [SLICE-1:0] w_or;
    wire [SLICE-1:0] w_xor;
    wire [SLICE-1:0] w_not_a;
    wire [SLICE-1:0] w_nand;
    wire [SLICE-1:0] w_nor;
    wire [SLICE-1:0] w_xnor;

    // Inverted ops reuse the base gate output through an inverter.
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        and u_and   (w_and[i],   a[i], b[i]);
        or  u_or    (w_or[i],    a[i], b[i]);
        xor u_xor   (w_xor[i],   a[i], b[i]);
        not u_inv_a (w_not_a[i], a[i]);
        not u_nand  (w_nand[i],  w_and[i]);
        not u_nor   (w_nor[i],   w_or[i]);
        not u_xnor  (w_xnor[i],  w_xor[i]);
    end

    always_comb begin
        y = a;
        case (op)
            OP_NOT:  y = w_not_a;
            OP_AND:  y = w_and;
            OP_NAND: y = w_nand;
            OP_OR:   y = w_or;
            OP_NOR:  y = w_nor;
            OP_XOR:  y = w_xor;
            OP_XNOR: y = w_xnor;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_serial.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_serial
// Description : Bitwise logic unit computing a WIDTH-bit result SLICE bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_serial
    import logic_unit_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int c_CNT_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(NUM_SLICES - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("logic_unit_serial: WIDTH must be a multiple of SLICE");
    end

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    int                 w_base;
    logic [SLICE-1:0]   w_slice_y;
    logic [WIDTH-1:0]   w_y_next;

    assign w_base = int'(r_cnt) * SLICE;

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op (r_op),
        .a  (r_a[w_base +: SLICE]),
        .b  (r_b[w_base +: SLICE]),
        .y  (w_slice_y)
    );

    // Next y with the current slice merged in, so zero sees the final write.
    always_comb begin
        w_y_next = y;
        w_y_next[w_base +: SLICE] = w_slice_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            y         <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op     <= op;
                        r_a      <= a;
                        r_b      <= b;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    y <= w_y_next;
                    if (r_cnt == c_LAST_CNT) begin
                        r_cnt     <= '0;
                        zero      <= (w_y_next == '0);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_serial
// Description : Self-checking bench for logic_unit_serial against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_serial;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default instance (WIDTH=32, SLICE=4)
    logic        in_valid0, in_ready0, out_valid0, out_ready0, zero0, busy0;
    logic [2:0]  op0;
    logic [31:0] a0, b0, y0;

    // WIDTH=8, SLICE=8
    logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, busy1;
    logic [2:0]  op1;
    logic [7:0]  a1, b1, y1;

    // WIDTH=16, SLICE=2
    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, busy2;
    logic [2:0]  op2;
    logic [15:0] a2, b2, y2;

    int checks   = 0;
    int failures = 0;

    logic_unit_serial u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .op(op0), .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .y(y0), .zero(zero0), .busy(busy0)
    );

    logic_unit_serial #(.WIDTH(8), .SLICE(8)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .zero(zero1), .busy(busy1)
    );

    logic_unit_serial #(.WIDTH(16), .SLICE(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .zero(zero2), .busy(busy2)
    );

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & z;
            3'd2:    return ~(x & z);
            3'd3:    return x | z;
            3'd4:    return ~(x | z);
            3'd5:    return x ^ z;
            3'd6:    return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    // Launch one op on the default instance, scramble inputs after accept,
    // and count edges until out_valid (bounded).
    task automatic do_op0(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z,
                          output int lat, output int busy_gaps);
        op0 = o; a0 = x; b0 = z; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        a0 = $urandom; b0 = $urandom; op0 = 3'($urandom);
        lat = 0; busy_gaps = 0;
        while (!out_valid0 && lat < 40) begin
            if (!busy0) busy_gaps++;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy0) busy_gaps++;
    endtask

    task automatic release0();
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (y0 !== 32'h0)      begin failures++; $display("FAIL reset_y: got %h expected 0", y0); end
        checks++; if (zero0 !== 1'b0)    begin failures++; $display("FAIL reset_zero: got %b expected 0", zero0); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        checks++; if (busy0 !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_and();
        int lat, gaps;
        do_op0(3'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, gaps);
        checks++; if (y0 !== 32'h00F0_1234) begin failures++; $display("FAIL and_y: got %h expected 00f01234", y0); end
        checks++; if (zero0 !== 1'b0) begin failures++; $display("FAIL and_zero: got %b expected 0", zero0); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL and_latency: got %0d expected 8", lat); end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL and_busy: busy low %0d cycles expected 0", gaps); end
        release0();
        checks++; if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL and_idle: in_ready=%b busy=%b expected 1 0", in_ready0, busy0); end
    endtask

    task automatic test_xor_xnor();
        int lat, gaps;
        do_op0(3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, gaps);
        checks++; if (y0 !== 32'h0 || zero0 !== 1'b1) begin failures++; $display("FAIL xor_equal: got y=%h zero=%b expected 00000000 1", y0, zero0); end
        release0();
        do_op0(3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, gaps);
        checks++; if (y0 !== 32'hFFFF_FFFF || zero0 !== 1'b0) begin failures++; $display("FAIL xnor_equal: got y=%h zero=%b expected ffffffff 0", y0, zero0); end
        release0();
    endtask

    // Consecutive random ops, each launched the cycle after the previous release.
    task automatic test_back_to_back();
        int lat, gaps;
        logic [2:0] o;
        logic [31:0] x, z, exp_y;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom);
            x = $urandom;
            z = (i % 6 == 0) ? x : $urandom;
            exp_y = model(o, x, z);
            checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready0); end
            do_op0(o, x, z, lat, gaps);
            checks++; if (y0 !== exp_y) begin failures++; $display("FAIL b2b_y[%0d] op=%0d: got %h expected %h", i, o, y0, exp_y); end
            checks++; if (zero0 !== (exp_y == 32'h0)) begin failures++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i, zero0, exp_y == 32'h0); end
            checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected 8", i, lat); end
            release0();
        end
    endtask

    task automatic test_backpressure();
        int lat, gaps;
        do_op0(3'd4, 32'h0, 32'h0, lat, gaps);
        checks++; if (lat !== 8) begin failures++; $display("FAIL bp_latency: got %0d expected 8", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid0 = (c == 2); op0 = 3'd1; a0 = 32'h1234_5678; b0 = 32'h0;
            @(posedge clk); #1;
            in_valid0 = 1'b0;
            checks++; if (y0 !== 32'hFFFF_FFFF || out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
                begin failures++; $display("FAIL bp_hold[%0d]: got y=%h out_valid=%b in_ready=%b expected ffffffff 1 0", c, y0, out_valid0, in_ready0); end
        end
        release0();
        checks++; if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0)
            begin failures++; $display("FAIL bp_idle: got in_ready=%b busy=%b out_valid=%b expected 1 0 0", in_ready0, busy0, out_valid0); end
        repeat (3) @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0 || y0 !== 32'hFFFF_FFFF)
            begin failures++; $display("FAIL bp_ignored: got busy=%b y=%h expected 0 ffffffff", busy0, y0); end
    endtask

    task automatic test_reset_mid_run();
        int lat, gaps;
        do_op0(3'd5, 32'h5555_AAAA, 32'h5555_AAAA, lat, gaps);
        release0();
        op0 = 3'd3; a0 = 32'h1357_9BDF; b0 = 32'h2468_ACE0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++; if (out_valid0 !== 1'b0 || y0 !== 32'h0 || zero0 !== 1'b0)
            begin failures++; $display("FAIL midrun_reset: got out_valid=%b y=%h zero=%b expected 0 0 0", out_valid0, y0, zero0); end
        checks++; if (busy0 !== 1'b0 || in_ready0 !== 1'b1)
            begin failures++; $display("FAIL midrun_reset_ctl: got busy=%b in_ready=%b expected 0 1", busy0, in_ready0); end
        @(posedge clk); #1;
        reset = 1'b0;
        do_op0(3'd0, 32'h0000_FFFF, 32'hFFFF_FFFF, lat, gaps);
        checks++; if (y0 !== 32'hFFFF_0000) begin failures++; $display("FAIL after_reset_not: got %h expected ffff0000", y0); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL after_reset_latency: got %0d expected 8", lat); end
        release0();
    endtask

    task automatic test_sweep();
        int lat;
        op1 = 3'd2; a1 = 8'hAA; b1 = 8'hFF; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (y1 !== 8'h55) begin failures++; $display("FAIL w8_nand_y: got %h expected 55", y1); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL w8_latency: got %0d expected 1", lat); end
        out_ready1 = 1'b1; @(posedge clk); #1; out_ready1 = 1'b0;

        op2 = 3'd7; a2 = 16'h8001; b2 = 16'($urandom); in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0; a2 = 16'h0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (y2 !== 16'h8001 || zero2 !== 1'b0) begin failures++; $display("FAIL w16_pass: got y=%h zero=%b expected 8001 0", y2, zero2); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL w16_latency: got %0d expected 8", lat); end
        out_ready2 = 1'b1; @(posedge clk); #1; out_ready2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid0 = 1'b0; out_ready0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
        test_reset();
        test_and();
        test_xor_xnor();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Parametrised bitwise logic unit and successor to the fixed 4-bit and 32-bit gate primitives.
- Supports eight selectable logic operations on WIDTH-bit operands.
- Computes the result SLICE bits per cycle under a small FSM, which keeps area low when WIDTH is large.
- Sits between the factorial datapath controller and the operand registers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH % SLICE != 0 is an elaboration error.
- NUM_SLICES, WIDTH/SLICE, derived. Not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept an operation.
- op  input  3  operation select (codes below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B. Ignored for NOT and PASS.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result register.
- zero  output  1  registered flag, y == 0. Meaningful while out_valid = 1.
- busy  output  1  high when state != IDLE.

Behaviour:
- Op codes:
  - 000 NOT a
  - 001 AND
  - 010 NAND
  - 011 OR
  - 100 NOR
  - 101 XOR
  - 110 XNOR
  - 111 PASS a
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, slice counter = 0.
  - y = 0, zero = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Latched operands are cleared to 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T0: latch a, b and op, set cnt = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge writes y[cnt*SLICE +: SLICE] = f(op, a_slice, b_slice) and increments cnt.
  - The write at cnt == NUM_SLICES-1 goes to DONE and sets zero = (final y == 0), including the slice being written that cycle.
- DONE:
  - out_valid = 1. y and zero are held stable.
  - On out_ready = 1 at an edge: go to IDLE.
  - y keeps its value until the next accepted op overwrites it slice by slice. zero is not cleared.
- Latency: out_valid rises NUM_SLICES edges after the accept edge (8 for defaults). With SLICE = WIDTH it rises 1 edge after accept.
- Throughput: one op per NUM_SLICES+2 cycles at best. in_ready is deasserted in RUN and DONE, so there is no overlap.
- in_valid is ignored in RUN and DONE. Changes on a, b or op after acceptance have no effect.
- Bits of y not yet rewritten during RUN hold the previous result. Consumers must only sample y while out_valid = 1.
- out_ready while not in DONE is ignored.
- Reset during RUN or DONE aborts the operation: no out_valid pulse, y = 0.
- Illegal op codes: none; all eight codes are defined.

Decomposition:
- Shared package:
  - Op code constants: OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_PASS.
  - State encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
- One sub-module, logic_slice: combinational, SLICE-bit, inputs op/a/b and output y.
  - Built from the existing and/or/xor/inv primitives.
  - Instantiated once. The top level multiplexes the operand slice selected by cnt into it.

Test Plan:
- AND, defaults: a = 0xF0F0_1234, b = 0x0FF0_FFFF, one-cycle in_valid.
  - y = 0x00F0_1234, zero = 0.
  - out_valid exactly 8 edges after accept; busy high throughout.
- XOR with a = b = 0xDEADBEEF: y = 0x0000_0000, zero = 1. XNOR with the same operands: y = 0xFFFF_FFFF, zero = 0.
- Backpressure: NOR a = 0, b = 0 with out_ready held low for 5 cycles after out_valid.
  - y = 0xFFFF_FFFF is stable and in_ready = 0.
  - A second in_valid during that window is ignored.
  - After out_ready: IDLE, in_ready = 1.
- Reset mid-RUN: assert reset after the 3rd slice write of an OR.
  - Outputs immediately take reset values (out_valid = 0, y = 0, zero = 0).
  - After release, NOT a = 0x0000_FFFF gives y = 0xFFFF_0000 with correct 8-cycle latency.
- Parameter sweep:
  - WIDTH = 8, SLICE = 8, NAND a = 0xAA, b = 0xFF: y = 0x55, latency 1 edge.
  - WIDTH = 16, SLICE = 2, PASS a = 0x8001: y = 0x8001, latency 8 edges.
